// File: rtl/decimation_cic.sv
// N-stage CIC decimator: pipelined integrators at the input rate, comb chain
// evaluated once per frame, output truncated to the input width.
module decimation_cic #(
    parameter int R    = 128,
    parameter int N    = 3,
    parameter int W_IN = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [W_IN-1:0] data_in,
    input  logic                   sync_in,
    output logic signed [W_IN-1:0] data_out,
    output logic                   out_valid
);

    localparam int LOG2R = $clog2(R);
    localparam int W_ACC = W_IN + N * LOG2R;
    localparam int PW    = (LOG2R < 1) ? 1 : LOG2R;
    localparam logic [PW-1:0] LAST_PHASE = PW'(R - 1);

    logic [PW-1:0]           phase_reg;
    logic                    dec_event;
    logic signed [W_ACC-1:0] x_ext;
    logic signed [W_ACC-1:0] comb_out;

    assign x_ext     = {{(W_ACC - W_IN){data_in[W_IN-1]}}, data_in};
    assign dec_event = (phase_reg == LAST_PHASE);

    // sync_in only realigns the frame; a coinciding decimation still fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (sync_in || dec_event) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + PW'(1);
        end
    end

    genvar gi;

    // Each integrator adds the previous stage's registered value (pipelined chain)
    for (gi = 0; gi < N; gi++) begin : g_int
        logic signed [W_ACC-1:0] acc_reg;
        logic signed [W_ACC-1:0] acc_in;

        if (gi == 0) begin : g_first
            assign acc_in = x_ext;
        end else begin : g_rest
            assign acc_in = g_int[gi-1].acc_reg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_reg <= '0;
            end else begin
                acc_reg <= acc_reg + acc_in;
            end
        end
    end

    for (gi = 0; gi < N; gi++) begin : g_comb
        logic signed [W_ACC-1:0] stage_in;
        logic signed [W_ACC-1:0] dly_reg;
        logic signed [W_ACC-1:0] diff;

        if (gi == 0) begin : g_first
            assign stage_in = g_int[N-1].acc_reg;
        end else begin : g_rest
            assign stage_in = g_comb[gi-1].diff;
        end

        assign diff = stage_in - dly_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dly_reg <= '0;
            end else if (dec_event) begin
                dly_reg <= stage_in;
            end
        end
    end

    assign comb_out = g_comb[N-1].diff;

    // Keeping the top W_IN bits divides out the R^N DC gain, rounding toward -inf
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= dec_event;
            if (dec_event) begin
                data_out <= comb_out[W_ACC-1 -: W_IN];
            end
        end
    end

endmodule
